booth_mult_seq: RTL
===================

# booth_mult_seq

Iterative radix-4 Booth multiplier, parametrised in operand width, with selectable signed/unsigned mode and a start/done handshake. It retires one Booth digit per clock, trading the fully parallel partial-product array of the combinational 8-bit multiplier for a small shift-add datapath. It is the multiply stage for area-constrained FMAC configurations, and its product feeds the accumulator adder.

## Interface
- WIDTH, 8: operand width in bits. Must be even and at least 4.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block can accept
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands
- x  input  WIDTH  multiplier (Booth-recoded operand); captured on accept
- y  input  WIDTH  multiplicand; captured on accept
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; held until the next accept

## Operation
- Internal operand width is E = WIDTH+2 bits.
  - signed_mode=1: x and y are sign-extended to E bits.
  - signed_mode=0: x and y are zero-extended to E bits.
  - This makes unsigned operands positive two's-complement numbers, so one datapath serves both modes.
- Iteration count is N = E/2 = WIDTH/2+1 in both modes. For WIDTH=8, N=5.
- States: IDLE, RUN, DONE.
  - IDLE, start=1: capture the operands and signed_mode, clear the accumulator, clear the step counter, go to RUN.
  - RUN: each cycle, form the Booth digit d from triplet {x[2i+1], x[2i], x[2i-1]}, with x[-1]=0.
    - d is one of {0, ±1, ±2}, selecting 0, ±Y or ±2Y.
    - Add the selected value to the accumulator at a weight of 4^i. A right-shifting (accumulator, x) register pair with arithmetic shift is acceptable.
    - The counter increments every RUN cycle. After the N-th step, go to DONE.
  - DONE: product is loaded with the low 2*WIDTH bits of the 2E-bit sum, and done=1.
    - start=1 in DONE: accept new operands immediately and go to RUN (back-to-back).
    - start=0 in DONE: go to IDLE.
- ±2Y and the negation are formed at E+1 bits, then sign-extended into the 2E-bit accumulator. Negation is one's complement plus carry-in, not a separate incrementer stage.
- The result is exact for all operand pairs in both modes, with no overflow or saturation:
  - signed range: −2^(2W−2) … 2^(2W−2)
  - unsigned range: up to (2^W−1)^2
- start is ignored while in RUN and has no effect on the operation in flight.
- x, y and signed_mode may change freely after accept; the block uses only the captured copies.
- rst=1 in any state, including mid-RUN:
  - next state is IDLE
  - busy=0, done=0, product=0, counter=0
  - the operation in flight is discarded

## Timing
- Reset values: busy=0, done=0, product=0, state=IDLE.
- The cycle in which start is sampled high in IDLE or DONE is the accept edge, call it t.
- busy is high for exactly N cycles, starting the cycle after t.
- done is high for exactly one cycle, the (N+1)-th cycle after t. product is valid from that cycle onward.
- Latency is N+1 cycles from accept to done. For WIDTH=8, done rises 6 cycles after accept.
- Back-to-back throughput is one result every N+1 cycles.
- product holds its value through IDLE and RUN of later operations. It changes only at the DONE load, or to 0 on reset.
- busy and done are never high together.

## Test plan
- WIDTH=8, signed: x=0x80, y=0x80 (−128·−128) -> done 6 cycles after accept, product=0x4000. x=0xFF, y=0x01 -> product=0xFFFF.
- WIDTH=8, unsigned: x=0xFF, y=0xFF -> product=0xFE01. Same operands in signed mode -> product=0x0001.
- Back-to-back:
  - start held high in the DONE cycle with x=7, y=−3 signed after a first op of 12·10 unsigned.
  - First done gives 0x0078. Second done arrives exactly 6 cycles later with 0xFFEB.
  - busy shows no IDLE gap between the two operations.
- Operand and start isolation:
  - toggle x, y, signed_mode and pulse start during RUN.
  - Result matches the captured operands, no extra done occurs, and the busy length is unchanged.
- Reset mid-operation: assert rst in the 3rd RUN cycle -> the next cycle shows busy=0, done=0, product=0. No done follows. A fresh start then completes normally.
- Randomised sweep at WIDTH=8, 16 and 32 in both modes, checked against a reference product.
  - Include the corner operands 0, 1, max and min.
  - Check the latency of N+1 on every operation.

Source files
------------

// File: rtl/booth_mult_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : booth_mult_seq_if
// Description : Handshake and operand/result bundle for booth_mult_seq.
//               master : drives start, signed_mode, x, y; observes busy,
//                        done, product.
//               slave  : the multiplier side of the same signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
) ();
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, x, y,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, x, y,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : booth_mult_seq
// Description : Iterative radix-4 Booth multiplier, one Booth digit per clock.
//               Operands are extended by two bits (sign- or zero-extension by
//               signed_mode) so a single signed datapath covers both modes.
// Ports       : clk         - rising-edge clock
//               rst         - synchronous active-high reset
//               bus (slave) - start/signed_mode/x/y in, busy/done/product out
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  wire             clk,
    input  wire             rst,
    booth_mult_seq_if.slave bus
);
    localparam int c_E  = WIDTH + 2;        // internal operand width
    localparam int c_N  = c_E / 2;          // Booth digits per operation
    localparam int c_CW = $clog2(c_N + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    // {r_hi, r_lo, r_prev} is the right-shifting product/multiplier pair.
    // r_hi carries two guard bits so that adding +/-2Y never overflows.
    logic [c_E+1:0]         r_hi;
    logic [c_E-1:0]         r_lo;
    logic                   r_prev;
    logic [c_E-1:0]         r_y;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_accept;
    logic [c_E-1:0]         w_x_ext;
    logic [c_E-1:0]         w_y_ext;
    logic [2:0]             w_trip;
    logic [c_E:0]           w_mag;
    logic                   w_neg;
    logic [c_E+1:0]         w_mag_ext;
    logic [c_E+1:0]         w_addend;
    logic [c_E+1:0]         w_sum;
    logic [c_E+1:0]         w_hi_next;
    logic [c_E-1:0]         w_lo_next;
    logic                   w_last;

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign w_x_ext = bus.signed_mode ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
    assign w_y_ext = bus.signed_mode ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y};

    // The current multiplier triplet always sits at the bottom of r_lo
    // because the pair shifts right by two each step.
    assign w_trip = {r_lo[1:0], r_prev};

    // Booth digit select: magnitude (Y or 2Y, E+1 bits) and sign.
    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (w_trip)
            3'b001, 3'b010: w_mag = {r_y[c_E-1], r_y};
            3'b011:         w_mag = {r_y, 1'b0};
            3'b100: begin
                w_mag = {r_y, 1'b0};
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_mag = {r_y[c_E-1], r_y};
                w_neg = 1'b1;
            end
            default: begin
                w_mag = '0;
                w_neg = 1'b0;
            end
        endcase
    end

    // Negation is one's complement with the +1 folded into the adder carry-in.
    assign w_mag_ext = {w_mag[c_E], w_mag};
    assign w_addend  = w_neg ? ~w_mag_ext : w_mag_ext;
    assign w_sum     = r_hi + w_addend + {{(c_E+1){1'b0}}, w_neg};

    // Arithmetic right shift of the whole pair by one Booth digit.
    assign w_hi_next = {{2{w_sum[c_E+1]}}, w_sum[c_E+1:2]};
    assign w_lo_next = {w_sum[1:0], r_lo[c_E-1:2]};

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_prev    <= 1'b0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_state <= S_RUN;
                r_hi    <= '0;
                r_lo    <= w_x_ext;
                r_prev  <= 1'b0;
                r_y     <= w_y_ext;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_hi   <= w_hi_next;
                        r_lo   <= w_lo_next;
                        r_prev <= r_lo[1];
                        r_cnt  <= r_cnt + c_CW'(1);
                        if (w_last) begin
                            // Low 2*WIDTH bits of the final shifted pair.
                            r_state   <= S_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_product <= {w_hi_next[WIDTH-3:0], w_lo_next};
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule
`default_nettype wire
